// File: rtl/demux_scheduler.sv
// demux_scheduler: routes serial beats to 4 destinations in BURST_LEN bursts.
// Define DEMUX_SCHEDULER_SKIP_EN to skip unready destinations when rotating.
module demux_scheduler #(
  parameter int BURST_LEN    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [3:0] dst_ready,
  output logic [1:0] sel,
  output logic [3:0] out,
  output logic [3:0] out_valid,
  output logic       burst_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ADV  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(BURST_LEN - 1);
  localparam logic [7:0] TO_LAST  = 8'(IDLE_TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [7:0] tout;
  logic       take;
  logic       last;
  logic       expire;
  logic [1:0] sel_nx;
  logic       adv_ok;

  assign take   = a_valid && a_ready;
  assign last   = take && (cnt == CNT_LAST);
  assign expire = (state == XFER) && !a_valid
                  && (tout == TO_LAST);

`ifdef DEMUX_SCHEDULER_SKIP_EN
  logic [1:0] cand;

  // nearest ready index wins, so scan farthest first
  always_comb begin
    sel_nx = sel;
    adv_ok = 1'b0;
    cand   = sel;
    for (int k = 4; k >= 1; k--) begin
      cand = sel + 2'(k);
      if (dst_ready[cand]) begin
        sel_nx = cand;
        adv_ok = 1'b1;
      end
    end
  end
`else
  assign sel_nx = sel + 2'd1;
  assign adv_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (a_valid) state_nx = XFER;
      XFER: begin
        if (last)
          state_nx = ADV;
        else if (expire)
          state_nx = (cnt != 4'd0) ? ADV : IDLE;
      end
      ADV:  if (adv_ok) state_nx = XFER;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    a_ready = (state == XFER) && dst_ready[sel];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel        <= 2'd0;
      cnt        <= 4'd0;
      tout       <= 8'd0;
      out        <= 4'd0;
      out_valid  <= 4'd0;
      burst_done <= 1'b0;
    end else begin
      out        <= 4'd0;
      out_valid  <= 4'd0;
      burst_done <= last || (expire && cnt != 4'd0);
      if (take) begin
        out[sel]       <= a;
        out_valid[sel] <= 1'b1;
        cnt            <= last ? 4'd0 : cnt + 4'd1;
      end else if (expire) begin
        cnt <= 4'd0;
      end
      if (state == XFER && !a_valid && !expire)
        tout <= tout + 8'd1;
      else
        tout <= 8'd0;
      if (state == ADV && adv_ok)
        sel <= sel_nx;
    end
  end

endmodule

// File: tb/tb_demux_scheduler.sv
// tb_demux_scheduler: directed bench with a per-cycle reference model.
// Covers streaming, stalls, timeouts, rotation policy and reset mid-burst.
module tb_demux_scheduler;

  localparam int BL = 4;
  localparam int IT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a;
  logic       a_valid;
  logic       a_ready;
  logic [3:0] dst_ready;
  logic [1:0] sel;
  logic [3:0] out;
  logic [3:0] out_valid;
  logic       burst_done;

  int checks   = 0;
  int failures = 0;

  demux_scheduler #(
    .BURST_LEN   (BL),
    .IDLE_TIMEOUT(IT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .dst_ready (dst_ready),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // phase: 0 waiting, 1 moving beats, 2 choosing next destination
  int         phase;
  int         msel;
  int         beats;
  int         idle;
  int         k;
  bit         mtake;
  bit         started = 1'b0;
  logic [3:0] eout;
  logic [3:0] evalid;
  logic       edone;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase   = 0;
      msel    = 0;
      beats   = 0;
      idle    = 0;
      eout    = 4'd0;
      evalid  = 4'd0;
      edone   = 1'b0;
      started = 1'b1;
    end else if (started) begin
      mtake  = (phase == 1) && a_valid && dst_ready[msel];
      assert (!(mtake && !a_valid && idle == IT - 1))
        else $error("transfer and timeout in one cycle");
      eout   = 4'd0;
      evalid = 4'd0;
      edone  = 1'b0;
      case (phase)
        0: if (a_valid) phase = 1;
        1: begin
          if (mtake) begin
            evalid[msel] = 1'b1;
            eout[msel]   = a;
            idle         = 0;
            beats        = beats + 1;
            if (beats == BL) begin
              beats = 0;
              edone = 1'b1;
              phase = 2;
            end
          end else if (a_valid) begin
            idle = 0;
          end else begin
            idle = idle + 1;
            if (idle == IT) begin
              idle = 0;
              if (beats > 0) begin
                beats = 0;
                edone = 1'b1;
                phase = 2;
              end else begin
                phase = 0;
              end
            end
          end
        end
        default: begin
`ifdef DEMUX_SCHEDULER_SKIP_EN
          if (dst_ready != 4'd0) begin
            k = 1;
            while (!dst_ready[(msel + k) % 4]) k++;
            msel  = (msel + k) % 4;
            phase = 1;
          end
`else
          msel  = (msel + 1) % 4;
          phase = 1;
`endif
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("sel", sel, msel);
      chk("out", out, eout);
      chk("out_valid", out_valid, evalid);
      chk("burst_done", burst_done, edone);
      chk("a_ready", a_ready,
          int'((phase == 1) && dst_ready[msel]));
    end
  end

  // am: 0/1 constant data, 2 toggle every cycle
  task automatic drive(input bit r, input bit v, input int am,
                       input logic [3:0] dr, input int n);
    for (int i = 0; i < n; i++) begin
      rst_n     = r;
      a_valid   = v;
      dst_ready = dr;
      a         = (am == 2) ? ~a : am[0];
      @(posedge clk);
      #1;
    end
  endtask

  int cnt_dst [4];
  int pulses;
  int pulse_at [4];

  initial begin
    a = 1'b0;
    drive(0, 0, 0, 4'hf, 2);
    chk("rst_sel", sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_burst_done", burst_done, 0);
    chk("rst_a_ready", a_ready, 0);

    // steady stream
    pulses = 0;
    for (int j = 0; j < 4; j++) cnt_dst[j] = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1, 1, 2, 4'hf, 1);
      for (int j = 0; j < 4; j++) cnt_dst[j] += int'(out_valid[j]);
      if (burst_done) begin
        if (pulses < 4) pulse_at[pulses] = i;
        pulses++;
      end
    end
    chk("stream_pulses", pulses, 4);
    chk("stream_first_pulse", pulse_at[0], 4);
    chk("stream_second_pulse", pulse_at[1], 9);
    chk("stream_beats0", cnt_dst[0], 7);
    chk("stream_beats1", cnt_dst[1], 4);
    chk("stream_beats3", cnt_dst[3], 4);

    // stall on sel 1
    drive(0, 0, 0, 4'hf, 1);
    drive(1, 1, 2, 4'hf, 7);
    chk("stall_sel_pre", sel, 1);
    chk("stall_ov_pre", out_valid, 2);
    drive(1, 1, 2, 4'hd, 20);
    chk("stall_a_ready", a_ready, 0);
    chk("stall_out_valid", out_valid, 0);
    chk("stall_sel", sel, 1);
    drive(1, 1, 2, 4'hf, 2);
    chk("stall_resume_nodone", burst_done, 0);
    drive(1, 1, 2, 4'hf, 1);
    chk("stall_resume_done", burst_done, 1);
    chk("stall_resume_ov", out_valid, 2);

    // idle timeout
    drive(0, 0, 0, 4'hf, 1);
    drive(1, 1, 1, 4'hf, 3);
    drive(1, 0, 0, 4'hf, 7);
    chk("to_early_done", burst_done, 0);
    chk("to_early_ready", a_ready, 1);
    drive(1, 0, 0, 4'hf, 1);
    chk("to_done", burst_done, 1);
    chk("to_sel_hold", sel, 0);
    drive(1, 0, 0, 4'hf, 1);
    chk("to_sel_next", sel, 1);
    drive(1, 0, 0, 4'hf, 7);
    chk("to_empty_ready", a_ready, 1);
    drive(1, 0, 0, 4'hf, 1);
    chk("to_idle_ready", a_ready, 0);
    chk("to_idle_sel", sel, 1);
    chk("to_idle_nodone", burst_done, 0);

    // rotation policy
    drive(0, 0, 0, 4'hf, 1);
    drive(1, 1, 1, 4'hf, 4);
    drive(1, 1, 1, 4'h9, 1);
    chk("rot_done", burst_done, 1);
    drive(1, 1, 1, 4'h9, 1);
`ifdef DEMUX_SCHEDULER_SKIP_EN
    chk("skip_sel", sel, 3);
    drive(1, 1, 1, 4'h9, 4);
    chk("skip_done", burst_done, 1);
    drive(1, 1, 1, 4'h0, 3);
    chk("skip_hold_sel", sel, 3);
    chk("skip_hold_ready", a_ready, 0);
    drive(1, 1, 1, 4'h4, 1);
    chk("skip_sel2", sel, 2);
    chk("skip_ready2", a_ready, 1);
`else
    chk("noskip_sel", sel, 1);
    chk("noskip_ready", a_ready, 0);
    drive(1, 1, 1, 4'h9, 3);
    chk("noskip_stall_ov", out_valid, 0);
    chk("noskip_stall_sel", sel, 1);
    drive(1, 1, 1, 4'h2, 1);
    chk("noskip_resume_ov", out_valid, 2);
`endif

    // reset mid-burst
    drive(0, 0, 0, 4'hf, 1);
    drive(1, 1, 2, 4'hf, 13);
    chk("mid_sel", sel, 2);
    chk("mid_ov", out_valid, 4);
    drive(0, 1, 2, 4'hf, 1);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_done", burst_done, 0);
    chk("mid_rst_ready", a_ready, 0);
    drive(1, 0, 0, 4'hf, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameter BURST_LEN, default 4, number of accepted beats routed to one destination before rotating; legal range 1..15.
REQ-002 Parameter IDLE_TIMEOUT, default 8, number of consecutive A_VALID-low cycles in XFER that abandons the current burst; legal range 1..255.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 A  input  1  serial data bit to be distributed.
REQ-006 A_VALID  input  1  A holds a valid beat.
REQ-007 A_READY  output  1  the block accepts A this cycle; combinational.
REQ-008 DST_READY  input  4  bit i high means destination i can take a beat.
REQ-009 SEL  output  2  registered index of the current destination.
REQ-010 OUT  output  4  registered demuxed data; only bit SEL may be nonzero.
REQ-011 OUT_VALID  output  4  registered one-hot strobe that marks the destination written this cycle.
REQ-012 BURST_DONE  output  1  registered one-cycle pulse on completion or abandonment of a burst.

Function
REQ-013 The state machine SHALL have three states: IDLE, XFER and ADV.
REQ-014 Transfer condition: A_VALID && A_READY. A_READY = (state==XFER) && DST_READY[SEL]; A_READY SHALL be 0 in IDLE and in ADV.
REQ-015 On a transfer, the next edge SHALL set OUT[SEL]=A and OUT_VALID[SEL]=1. All other OUT and OUT_VALID bits SHALL be 0. Latency is one cycle.
REQ-016 When no transfer occurs, the next edge SHALL clear OUT and OUT_VALID to 0.
REQ-017 IDLE -> XFER when A_VALID=1. SEL is unchanged and no beat is accepted in that cycle.
REQ-018 Beat counter CNT (4 bits) increments on each transfer. A transfer with CNT==BURST_LEN-1 SHALL:
- set CNT=0;
- pulse BURST_DONE;
- move to ADV.
REQ-019 With BURST_LEN=1, every transfer SHALL end the burst.
REQ-020 Timeout counter TO (8 bits):
- increments on each XFER cycle with A_VALID=0;
- clears on any cycle with A_VALID=1, including stalls where DST_READY[SEL]=0;
- clears on leaving XFER.
REQ-021 When TO reaches IDLE_TIMEOUT-1 with A_VALID=0:
- with CNT>0, the block SHALL move to ADV, set CNT=0 and pulse BURST_DONE;
- with CNT==0, the block SHALL move to IDLE with SEL unchanged and no pulse.
REQ-022 A stall (A_VALID=1, DST_READY[SEL]=0) SHALL hold the state, CNT and SEL indefinitely.
REQ-023 ADV SHALL compute the next SEL per REQ-030/031 and return to XFER. SEL SHALL wrap from 3 to 0.
REQ-024 SEL SHALL change only on the ADV exit edge.
REQ-025 In a cycle where a transfer completes a burst and the timeout condition also holds, the transfer SHALL take precedence. This cannot occur by construction, and the bench checks it with an assertion.

Reset
REQ-026 With RST_N=0 at a rising edge, the block SHALL set:
- state=IDLE, SEL=0, CNT=0, TO=0;
- OUT=4'b0000, OUT_VALID=4'b0000, BURST_DONE=0.
REQ-027 A reset mid-burst SHALL abandon the burst with no BURST_DONE pulse. A_READY SHALL be 0 in the cycle after the reset edge.
REQ-028 Reset SHALL override every other condition in the same cycle.

Configuration
REQ-029 Macro DEMUX_SCHEDULER_SKIP_EN selects the ADV policy.
REQ-030 With DEMUX_SCHEDULER_SKIP_EN defined:
- ADV SHALL select the first index after SEL, in circular order SEL+1, SEL+2, SEL+3, SEL, whose DST_READY bit is 1;
- if all DST_READY bits are 0, the block SHALL stay in ADV with SEL unchanged.
REQ-031 With DEMUX_SCHEDULER_SKIP_EN undefined, ADV SHALL set SEL=SEL+1 mod 4 unconditionally and move to XFER after one cycle. The block then stalls per REQ-022 if that destination is not ready.

Verification
REQ-032 Reset then steady stream, with BURST_LEN=4, DST_READY=4'b1111, A_VALID=1 and A toggling: beats 0-3 appear with OUT_VALID=0001, beats 4-7 with 0010, then 0100 and 1000, then back to 0001. BURST_DONE pulses every 4 beats plus one ADV cycle.
REQ-033 Stall: in XFER with SEL=1, DST_READY=4'b1101 for 20 cycles with A_VALID=1 gives A_READY=0, no OUT_VALID and no timeout. Raising DST_READY[1] resumes transfers with CNT preserved.
REQ-034 Timeout: 2 beats to SEL=0, then A_VALID=0 for 8 cycles gives a BURST_DONE pulse, then ADV, then SEL=1. With CNT=0 and 8 idle cycles, the block returns to IDLE with SEL unchanged.
REQ-035 Skip, macro defined: SEL=0 burst ends with DST_READY=4'b1001, so the next SEL=3. With DST_READY=0000 in ADV, the block holds until a bit rises.
REQ-036 No skip, macro undefined: the same stimulus as REQ-035 gives the next SEL=1 and a stall until DST_READY[1]=1.
REQ-037 Reset mid-burst: RST_N=0 for 1 cycle after beat 2 of SEL=2 gives SEL=0, OUT=0000 and OUT_VALID=0000 on the next edge, with no BURST_DONE pulse.
